add_share_arb: RTL and testbench

- Shares one signed fixed-point adder (19-bit two's complement, data1 + data2) among NUM_REQ requesters.
- Arbitration is round-robin; every request port and the result port use a valid/ready handshake.
- Each result is held in one registered output stage with saturation or wrap on overflow, and is tagged with the ID of the requester that issued it.
- Sits between the per-channel fixed-point pipelines and the single shared adder resource in the datapath.

---
 rtl/add_share_arb.sv | 144 ++++++++++++++
 tb/tb_add_share_arb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_share_arb.sv
// add_share_arb: one signed fixed-point adder shared by NUM_REQ requesters.
// Round-robin grant, valid/ready on every port, a single registered result
// stage with saturate-or-wrap overflow handling and a requester ID tag.
module add_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 19,
  parameter int ID_W    = 2,
  parameter bit SAT_EN  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data1,
  input  logic [NUM_REQ*DATA_W-1:0] req_data2,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_data,
  output logic [ID_W-1:0]           res_id,
  output logic                      res_ovf
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   data_q;
  logic [ID_W-1:0]     id_q;
  logic                ovf_q;
  logic [ID_W-1:0]     last_grant_q;

  logic                can_accept_s;
  logic                grant_any_s;
  logic [ID_W-1:0]     grant_id_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic [DATA_W-1:0]   op1_s;
  logic [DATA_W-1:0]   op2_s;
  logic [DATA_W:0]     sum_s;
  logic [DATA_W:0]     fit_d;

  // Fit a DATA_W+1 bit sum into DATA_W bits; returns {overflow, data}.
  function automatic logic [DATA_W:0] fit_sum(input logic [DATA_W:0] s);
    logic             ovf;
    logic [DATA_W-1:0] d;
    ovf = s[DATA_W] ^ s[DATA_W-1];
    if (SAT_EN && ovf) begin
      if (s[DATA_W]) begin
        d = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        d = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end else begin
      d = s[DATA_W-1:0];
    end
    return {ovf, d};
  endfunction

  // The output register can take a new result when empty or draining now;
  // nothing is granted while reset is held.
  assign can_accept_s = rst_n & ((state_q == ST_EMPTY) | res_ready);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    idx         = 0;
    grant_any_s = 1'b0;
    grant_id_s  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_id_s  = (!grant_any_s && can_accept_s && (idx == i) && req_valid[i])
                      ? ID_W'(i) : grant_id_s;
        grant_any_s = grant_any_s | (can_accept_s && (idx == i) && req_valid[i]);
      end
    end
  end

  // One-hot grant vector and operand mux for the granted requester.
  always_comb begin
    grant_s = '0;
    op1_s   = '0;
    op2_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_s[i] = grant_any_s & (grant_id_s == ID_W'(i));
      op1_s      = op1_s | (grant_s[i] ? req_data1[i*DATA_W +: DATA_W] : '0);
      op2_s      = op2_s | (grant_s[i] ? req_data2[i*DATA_W +: DATA_W] : '0);
    end
  end

  assign req_ready = grant_s;

  // Sign-extended add of the selected pair, then overflow handling.
  assign sum_s = {op1_s[DATA_W-1], op1_s} + {op2_s[DATA_W-1], op2_s};
  assign fit_d = fit_sum(sum_s);

  // Result-stage FSM: load on grant, drain on res_ready, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      id_q         <= '0;
      ovf_q        <= 1'b0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (grant_any_s) begin
            state_q      <= ST_FULL;
            data_q       <= fit_d[DATA_W-1:0];
            ovf_q        <= fit_d[DATA_W];
            id_q         <= grant_id_s;
            last_grant_q <= grant_id_s;
          end else begin
            state_q      <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (grant_any_s) begin
            state_q      <= ST_FULL;
            data_q       <= fit_d[DATA_W-1:0];
            ovf_q        <= fit_d[DATA_W];
            id_q         <= grant_id_s;
            last_grant_q <= grant_id_s;
          end else if (res_ready) begin
            state_q      <= ST_EMPTY;
          end else begin
            state_q      <= ST_FULL;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign res_data  = data_q;
  assign res_id    = id_q;
  assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: a saturating and a wrapping instance share the same
// stimulus; a reference model predicts grants and pushes expected results into
// a queue that an independent monitor pops whenever a result is presented.
module tb_add_share_arb;

  localparam int N  = 4;
  localparam int DW = 19;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data1;
  logic [N*DW-1:0] req_data2;
  logic            res_ready;

  logic [N-1:0]    req_ready_s, req_ready_w;
  logic            res_valid_s, res_valid_w;
  logic [DW-1:0]   res_data_s, res_data_w;
  logic [1:0]      res_id_s, res_id_w;
  logic            res_ovf_s, res_ovf_w;

  add_share_arb #(.NUM_REQ(N), .DATA_W(DW), .ID_W(2), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_data1(req_data1), .req_data2(req_data2), .res_valid(res_valid_s),
    .res_ready(res_ready), .res_data(res_data_s), .res_id(res_id_s), .res_ovf(res_ovf_s)
  );

  add_share_arb #(.NUM_REQ(N), .DATA_W(DW), .ID_W(2), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w),
    .req_data1(req_data1), .req_data2(req_data2), .res_valid(res_valid_w),
    .res_ready(res_ready), .res_data(res_data_w), .res_id(res_id_w), .res_ovf(res_ovf_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] sat;
    logic [DW-1:0] wrp;
    logic [1:0]    id;
    bit            ovf;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  bit            pv[N];
  logic [DW-1:0] d1[N];
  logic [DW-1:0] d2[N];
  int            ptr;
  bit            mv;
  int            last_g;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic with plain integers.
  task automatic ref_add(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [DW-1:0] sat, output logic [DW-1:0] wrp, output bit ovf);
    int          sa, sb, s;
    logic [31:0] su;
    sa  = $signed(a);
    sb  = $signed(b);
    s   = sa + sb;
    su  = s;
    ovf = (s > 262143) || (s < -262144);
    wrp = su[DW-1:0];
    if (s > 262143)       sat = 19'h3FFFF;
    else if (s < -262144) sat = 19'h40000;
    else                  sat = su[DW-1:0];
  endtask

  function automatic logic [DW-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 19'h3FFFF - 19'($urandom_range(0, 15));
      1:       return 19'h40000 + 19'($urandom_range(0, 15));
      default: return 19'($urandom);
    endcase
  endfunction

  task automatic load(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    pv[i] = 1'b1;
    d1[i] = a;
    d2[i] = b;
  endtask

  // One clock of stimulus plus model prediction of grant and result.
  task automatic step(input bit rr);
    int         g;
    bit         ca;
    logic [3:0] er;
    exp_t       e;
    @(negedge clk);
    res_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = pv[i];
      req_data1[i*DW +: DW]   = d1[i];
      req_data2[i*DW +: DW]   = d2[i];
    end
    #1;
    chk("res_valid", res_valid_s, mv);
    chk("wrap_res_valid", res_valid_w, mv);
    ca = !mv || rr;
    g  = -1;
    if (ca) begin
      for (int k = 1; k <= N; k++) begin
        int idx = (ptr + k) % N;
        if (g < 0 && pv[idx]) g = idx;
      end
    end
    er = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("req_ready", req_ready_s, er);
    chk("wrap_req_ready", req_ready_w, er);
    last_g = g;
    if (g >= 0) begin
      ref_add(d1[g], d2[g], e.sat, e.wrp, e.ovf);
      e.id = 2'(g);
      q.push_back(e);
      ptr   = g;
      pv[g] = 1'b0;
      mv    = 1'b1;
    end else if (rr) begin
      mv = 1'b0;
    end
  endtask

  // Monitor: compare every presented result against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && res_valid_s) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          chk("res_data", res_data_s, q[0].sat);
          chk("res_id", res_id_s, q[0].id);
          chk("res_ovf", res_ovf_s, q[0].ovf);
          chk("wrap_res_data", res_data_w, q[0].wrp);
          chk("wrap_res_ovf", res_ovf_w, q[0].ovf);
          chk("wrap_res_id", res_id_w, q[0].id);
          if (res_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    res_ready = 1'b0;
    req_valid = 4'hF;
    req_data1 = '0;
    req_data2 = '0;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0; d1[i] = '0; d2[i] = '0;
    end
    ptr = N - 1;
    mv  = 1'b0;
    #2;
    chk("reset_valid", res_valid_s, 1'b0);
    chk("reset_data", res_data_s, 19'h0);
    chk("reset_id", res_id_s, 2'd0);
    chk("reset_ovf", res_ovf_s, 1'b0);
    chk("reset_no_ready", req_ready_s, 4'b0000);
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic sum and overflow cases.
    load(0, 19'h00010, 19'h7FFFB);
    step(1'b1);
    chk("basic_grant", req_ready_s, 4'b0001);
    load(2, 19'h3FFFF, 19'h00001);
    step(1'b1);
    chk("basic_data", res_data_s, 19'h0000B);
    chk("basic_id", res_id_s, 2'd0);
    chk("basic_ovf", res_ovf_s, 1'b0);
    load(3, 19'h40000, 19'h7FFFF);
    step(1'b1);
    chk("possat_data", res_data_s, 19'h3FFFF);
    chk("possat_ovf", res_ovf_s, 1'b1);
    chk("possat_id", res_id_s, 2'd2);
    chk("poswrap_data", res_data_w, 19'h40000);
    step(1'b1);
    chk("negsat_data", res_data_s, 19'h40000);
    chk("negsat_ovf", res_ovf_s, 1'b1);
    chk("negwrap_data", res_data_w, 19'h3FFFF);
    step(1'b1);
    chk("drained", res_valid_s, 1'b0);

    // Round-robin with all requesters active.
    for (int i = 0; i < N; i++) load(i, rnd_op(), rnd_op());
    for (int r = 0; r < 8; r++) begin
      step(1'b1);
      chk("rr_order", last_g, r % N);
      if (last_g >= 0) load(last_g, rnd_op(), rnd_op());
    end
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    step(1'b1);

    // Backpressure with two requesters, then zero-bubble replace.
    load(1, rnd_op(), rnd_op());
    load(2, rnd_op(), rnd_op());
    step(1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b0);
      chk("bp_no_ready", req_ready_s, 4'b0000);
      chk("bp_hold_id", res_id_s, 2'd1);
    end
    step(1'b1);
    chk("bp_replace_grant", req_ready_s, 4'b0100);
    step(1'b1);
    chk("bp_next_id", res_id_s, 2'd2);
    step(1'b1);

    // Asynchronous reset with a result pending.
    load(0, rnd_op(), rnd_op());
    step(1'b0);
    @(negedge clk);
    chk("pre_reset_valid", res_valid_s, 1'b1);
    #5;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", res_valid_s, 1'b0);
    chk("async_rst_data", res_data_s, 19'h0);
    q.delete();
    mv  = 1'b0;
    ptr = N - 1;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("rst_no_ready", req_ready_s, 4'b0000);
    chk("rst_no_ready_wrap", req_ready_w, 4'b0000);
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) load(i, rnd_op(), rnd_op());
    step(1'b1);
    chk("rst_first_grant", req_ready_s, 4'b0001);

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) load(i, rnd_op(), rnd_op());
      end
      step($urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 12; c++) step(1'b1);
    chk("queue_empty", q.size(), 0);
    chk("final_idle", res_valid_s, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
